// File: rtl/psum_acc.sv
// psum_acc: partial-sum accumulator with int8 requantisation.
//   Accumulates acc_len signed 16-bit products on top of a 32-bit bias,
//   then rounds, arithmetic-right-shifts, optionally applies ReLU
//   (never for GAP) and saturates to int8.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mode, start         layer mode (0=CV,1=DW,2=PW,3=GAP), begin request
//   acc_len, bias,      configuration latched on an accepted start
//   shift, relu_en
//   in_valid, in_ready, product      product stream from the PE array
//   out_valid, out_ready, out_data   int8 result handshake
//   busy, done          not-IDLE flag, one-cycle completion pulse
module psum_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic        start,
    input  logic [9:0]  acc_len,
    input  logic [31:0] bias,
    input  logic [4:0]  shift,
    input  logic        relu_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] product,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, ACC, POST, OUT} state_e;
    typedef enum logic [1:0] {MODE_CV, MODE_DW, MODE_PW, MODE_GAP} mode_e;

    state_e      state_q;
    mode_e       mode_q;
    logic [9:0]  len_q;
    logic [4:0]  shift_q;
    logic        relu_q;
    logic [31:0] acc_q;
    logic [9:0]  cnt_q;
    logic [7:0]  out_data_q;
    logic        done_q;

    logic        accept;
    logic        last;
    logic [9:0]  eff_len;

    logic signed [32:0] rnd33;
    logic signed [32:0] sum33;
    logic signed [32:0] shr33;
    logic signed [32:0] r33;
    logic        [7:0]  sat_d;

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign done      = done_q;

    assign accept  = in_valid && (state_q == ACC);
    assign eff_len = (len_q == 10'd0) ? 10'd1 : len_q;
    assign last    = (cnt_q == eff_len - 10'd1);

    // Round-half-up then arithmetic shift in 33 bits so the rounding
    // increment can never overflow the accumulator range.
    always_comb begin
        rnd33 = '0;
        if (shift_q != 5'd0) begin
            rnd33 = 33'sd1 <<< (shift_q - 5'd1);
        end
        sum33 = $signed({acc_q[31], acc_q}) + rnd33;
        shr33 = sum33 >>> shift_q;
        r33   = shr33;
        if (relu_q && (mode_q != MODE_GAP) && (shr33 < 0)) begin
            r33 = '0;
        end
        if (r33 > 33'sd127) begin
            sat_d = 8'h7F;
        end else if (r33 < -33'sd128) begin
            sat_d = 8'h80;
        end else begin
            sat_d = r33[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= MODE_CV;
            len_q      <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode_e'(mode);
                        len_q   <= acc_len;
                        shift_q <= shift;
                        relu_q  <= relu_en;
                        acc_q   <= bias;
                        cnt_q   <= '0;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_q <= acc_q + {{16{product[15]}}, product};
                        cnt_q <= cnt_q + 10'd1;
                        if (last) begin
                            state_q <= POST;
                        end
                    end
                end
                POST: begin
                    out_data_q <= sat_d;
                    state_q    <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_acc.sv
module tb_psum_acc;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        start;
    logic [9:0]  acc_len;
    logic [31:0] bias;
    logic [4:0]  shift;
    logic        relu_en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] product;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    psum_acc dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .start     (start),
        .acc_len   (acc_len),
        .bias      (bias),
        .shift     (shift),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [1:0]       mode;
        logic [9:0]       len;
        logic [31:0]      bias;
        logic [4:0]       shift;
        logic             relu;
        int               n;
        logic [3:0][15:0] p;
        logic [7:0]       exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [1:0] m, input logic [9:0] l,
                                input logic [31:0] b, input logic [4:0] s, input logic r,
                                input int n, input logic [15:0] p0, input logic [15:0] p1,
                                input logic [15:0] p2, input logic [15:0] p3,
                                input logic [7:0] e);
        vec_t v;
        v.name = name; v.mode = m; v.len = l; v.bias = b; v.shift = s; v.relu = r;
        v.n = n; v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3; v.exp = e;
        return v;
    endfunction

    // Called at #1 after a rising edge with the DUT in IDLE.
    task automatic begin_op(input vec_t v);
        mode = v.mode; acc_len = v.len; bias = v.bias; shift = v.shift; relu_en = v.relu;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({v.name, "_busy"}, {31'd0, busy}, 32'd1);
        chk({v.name, "_inrdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        begin_op(v);
        for (int i = 0; i < v.n; i++) begin
            in_valid = 1'b1;
            product  = v.p[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk({v.name, "_post_ov"}, {31'd0, out_valid}, 32'd0);
        chk({v.name, "_post_inrdy"}, {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk({v.name, "_ov"}, {31'd0, out_valid}, 32'd1);
        chk({v.name, "_data"}, {24'd0, out_data}, {24'd0, v.exp});
        chk({v.name, "_nodone"}, {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk({v.name, "_done"}, {31'd0, done}, 32'd1);
        chk({v.name, "_idle"}, {30'd0, busy, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk({v.name, "_done_end"}, {31'd0, done}, 32'd0);
        chk({v.name, "_hold"}, {24'd0, out_data}, {24'd0, v.exp});
    endtask

    initial begin
        rst = 1'b1; mode = '0; start = 1'b0; acc_len = '0; bias = '0; shift = '0;
        relu_en = 1'b0; in_valid = 1'b0; product = '0; out_ready = 1'b1;

        vecs[0]  = mk("basic32",  2'd0, 10'd4, 32'd0, 5'd0, 1'b0, 4, 16'd10, 16'd20, -16'sd5, 16'd7, 8'h20);
        vecs[1]  = mk("satpos",   2'd0, 10'd2, 32'd0, 5'd0, 1'b0, 2, 16'd200, 16'd100, 16'd0, 16'd0, 8'h7F);
        vecs[2]  = mk("satneg",   2'd0, 10'd2, 32'd0, 5'd0, 1'b0, 2, -16'sd200, -16'sd100, 16'd0, 16'd0, 8'h80);
        vecs[3]  = mk("relu_pw",  2'd2, 10'd1, 32'd0, 5'd0, 1'b1, 1, -16'sd50, 16'd0, 16'd0, 16'd0, 8'h00);
        vecs[4]  = mk("relu_gap", 2'd3, 10'd1, 32'd0, 5'd0, 1'b1, 1, -16'sd50, 16'd0, 16'd0, 16'd0, 8'hCE);
        vecs[5]  = mk("gap_pos",  2'd3, 10'd4, 32'd0, 5'd2, 1'b0, 4, 16'd5, 16'd5, 16'd5, 16'd6, 8'h05);
        vecs[6]  = mk("gap_neg",  2'd3, 10'd4, 32'd0, 5'd2, 1'b0, 4, -16'sd5, -16'sd5, -16'sd5, -16'sd6, 8'hFB);
        vecs[7]  = mk("gap_bias", 2'd3, 10'd4, 32'd3, 5'd2, 1'b0, 4, 16'd5, 16'd5, 16'd5, 16'd6, 8'h06);
        vecs[8]  = mk("len0",     2'd0, 10'd0, 32'd0, 5'd0, 1'b0, 1, 16'd9, 16'd0, 16'd0, 16'd0, 8'h09);
        vecs[9]  = mk("shift31",  2'd0, 10'd1, 32'h7FFFFFFF, 5'd31, 1'b0, 1, 16'd0, 16'd0, 16'd0, 16'd0, 8'h01);
        vecs[10] = mk("wrap",     2'd0, 10'd1, 32'h7FFFFFFF, 5'd0, 1'b0, 1, 16'd1, 16'd0, 16'd0, 16'd0, 8'h80);
        vecs[11] = mk("relu_dw",  2'd1, 10'd1, 32'd0, 5'd0, 1'b1, 1, -16'sd3, 16'd0, 16'd0, 16'd0, 8'h00);

        #12;
        chk("rst_outputs", {27'd0, in_ready, out_valid, busy, done, 1'b0}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // start during ACC must be ignored
        begin_op(vecs[0]);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            product  = vecs[0].p[i];
            if (i == 1) begin
                start = 1'b1; mode = 2'd3; acc_len = 10'd1; bias = 32'd1000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("ign_start_data", {24'd0, out_data}, 32'h20);
        @(posedge clk); #1;
        chk("ign_start_done", {31'd0, done}, 32'd1);

        // out_ready backpressure, then a start in the done cycle
        vecs[8].mode = 2'd0; vecs[8].len = 10'd1;
        out_ready = 1'b0;
        begin_op(vecs[8]);
        in_valid = 1'b1; product = 16'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ov", {31'd0, out_valid}, 32'd1);
            chk("bp_data", {24'd0, out_data}, 32'h09);
            chk("bp_inrdy_done", {30'd0, in_ready, done}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("bp_ov_last", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        chk("bp_done", {31'd0, done}, 32'd1);
        mode = 2'd0; acc_len = 10'd1; bias = 32'd0; shift = 5'd0; relu_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_cycle_start", {31'd0, busy}, 32'd1);
        in_valid = 1'b1; product = 16'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("done_cycle_data", {24'd0, out_data}, 32'h05);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // reset mid-accumulation
        vecs[0].bias = 32'd1000;
        begin_op(vecs[0]);
        in_valid = 1'b1; product = 16'd100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("midrst_outputs", {28'd0, in_ready, out_valid, busy, done}, 32'd0);
        chk("midrst_data", {24'd0, out_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        vecs[8].name = "post_rst";
        run_vec(vecs[8]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
